// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: latches two operands, adds one LSB-first bit pair per clock through
// a one-bit full-adder cell, and pulses done when the WIDTH-bit sum and flags are ready.
module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] operandA,
    input  logic [WIDTH-1:0] operandB,
    input  logic             carryIn,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carryOut,
    output logic             overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    // Full-adder cell inputs and outputs for the current bit position.
    logic fa_x, fa_y, fa_sum, fa_cout;

    always_comb begin
        fa_x    = a_sr_q[0];
        fa_y    = b_sr_q[0];
        fa_sum  = fa_x ^ fa_y ^ c_q;
        fa_cout = (fa_x & fa_y) | (c_q & (fa_x ^ fa_y));
    end

    always_comb begin
        state_d     = state_q;
        a_sr_d      = a_sr_q;
        b_sr_d      = b_sr_q;
        c_d         = c_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    a_sr_d      = operandA;
                    b_sr_d      = operandB;
                    c_d         = carryIn;
                    cnt_d       = '0;
                    result_d    = '0;
                    carry_out_d = 1'b0;
                    overflow_d  = 1'b0;
                    state_d     = StShift;
                end
            end
            StShift: begin
                result_d = {fa_sum, result_q[WIDTH-1:1]};
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                c_d      = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    carry_out_d = fa_cout;
                    // Carry into the MSB differs from carry out of it on signed overflow.
                    overflow_d  = c_q ^ fa_cout;
                    state_d     = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StShift);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            c_q         <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sr_q      <= a_sr_d;
            b_sr_q      <= b_sr_d;
            c_q         <= c_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign carryOut = carry_out_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed scenarios plus randomized back-to-back adds
// checked against a plain-arithmetic reference model.
module tb_serial_adder_ctrl;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] operandA;
    logic [W-1:0] operandB;
    logic         carryIn;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carryOut;
    logic         overflow;

    int tests_run;
    int tests_failed;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .operandA (operandA),
        .operandB (operandB),
        .carryIn  (carryIn),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carryOut (carryOut),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: full-width sum and signed-overflow rule.
    function automatic logic [W:0] ref_sum(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
        int unsigned s;
        s = int'(a) + int'(b) + int'(cin);
        return s[W:0];
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic cin);
        logic [W:0] s;
        s = ref_sum(a, b, cin);
        return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one add from IDLE; scrambles operand inputs after the accept edge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                          output logic got, output logic acc, output int lat,
                          output logic [W-1:0] r, output logic co, output logic ov);
        @(negedge clk);
        operandA = a;
        operandB = b;
        carryIn  = cin;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        acc      = busy;
        operandA = W'($urandom);
        operandB = W'($urandom);
        carryIn  = 1'($urandom);
        got = 1'b0;
        lat = 0;
        r   = '0;
        co  = 1'b0;
        ov  = 1'b0;
        while (lat < int'(W) + 4) begin
            if (done) begin
                got = 1'b1;
                r   = result;
                co  = carryOut;
                ov  = overflow;
                break;
            end
            tick();
            lat++;
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        operandA = '0;
        operandB = '0;
        carryIn = 1'b0;
        repeat (3) tick();
        tests_run++;
        if ({busy, done, result, carryOut, overflow} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got busy=%b done=%b result=%h co=%b ov=%b, want all 0",
                     busy, done, result, carryOut, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tests_run++;
        if ({busy, done, result} !== '0) begin
            tests_failed++;
            $display("FAIL reset_release: got busy=%b done=%b result=%h, want 0", busy, done, result);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [4] = '{8'h0F, 8'hFF, 8'h7F, 8'h80};
        logic [W-1:0] tb [4] = '{8'h01, 8'h01, 8'h01, 8'h80};
        logic         tc [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic [W:0]   exp_s;
        logic         exp_o;
        for (int t = 0; t < 4; t++) begin
            exp_s = ref_sum(ta[t], tb[t], tc[t]);
            exp_o = ref_ovf(ta[t], tb[t], tc[t]);
            @(negedge clk);
            operandA = ta[t];
            operandB = tb[t];
            carryIn  = tc[t];
            start    = 1'b1;
            tick();
            start = 1'b0;
            for (int e = 0; e < int'(W); e++) begin
                tests_run++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL shift_busy op%0d step%0d: got busy=%b done=%b, want 1/0",
                             t, e, busy, done);
                end
                tick();
            end
            tests_run++;
            if (busy !== 1'b0 || done !== 1'b1 || result !== exp_s[W-1:0] ||
                carryOut !== exp_s[W] || overflow !== exp_o) begin
                tests_failed++;
                $display("FAIL done_result op%0d: got busy=%b done=%b r=%h co=%b ov=%b, want 0/1 %h %b %b",
                         t, busy, done, result, carryOut, overflow, exp_s[W-1:0], exp_s[W], exp_o);
            end
            repeat (4) begin
                tick();
                tests_run++;
                if (done !== 1'b0 || busy !== 1'b0 || result !== exp_s[W-1:0] ||
                    carryOut !== exp_s[W] || overflow !== exp_o) begin
                    tests_failed++;
                    $display("FAIL hold op%0d: got done=%b busy=%b r=%h co=%b ov=%b, want 0/0 %h %b %b",
                             t, done, busy, result, carryOut, overflow, exp_s[W-1:0], exp_s[W],
                             exp_o);
                end
            end
        end
    endtask

    task automatic test_start_held();
        @(negedge clk);
        operandA = 8'h11;
        operandB = 8'h22;
        carryIn  = 1'b0;
        start    = 1'b1;
        tick();
        operandA = 8'hAA;
        operandB = 8'h55;
        repeat (W) tick();
        tests_run++;
        if (done !== 1'b1 || result !== 8'h33 || carryOut !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_first: got done=%b r=%h co=%b, want 1 33 0", done, result, carryOut);
        end
        tick();
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 8'h33) begin
            tests_failed++;
            $display("FAIL held_idle_gap: got busy=%b done=%b r=%h, want 0 0 33", busy, done, result);
        end
        tick();
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || result !== 8'h00) begin
            tests_failed++;
            $display("FAIL held_restart: got busy=%b r=%h, want 1 00", busy, result);
        end
        repeat (W) tick();
        tests_run++;
        if (done !== 1'b1 || result !== 8'hFF || carryOut !== 1'b0) begin
            tests_failed++;
            $display("FAIL held_second: got done=%b r=%h co=%b, want 1 FF 0", done, result, carryOut);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic got, acc, co, ov;
        logic [W-1:0] r;
        int lat;
        int seen;
        @(negedge clk);
        operandA = 8'hF3;
        operandB = 8'h2C;
        carryIn  = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({busy, done, result, carryOut, overflow} !== '0) begin
            tests_failed++;
            $display("FAIL async_reset: got busy=%b done=%b r=%h co=%b ov=%b, want all 0",
                     busy, done, result, carryOut, overflow);
        end
        #2;
        rst_n = 1'b1;
        seen = 0;
        repeat (W + 3) begin
            tick();
            if (done || busy) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %0d active cycles, want 0", seen);
        end
        run_op(8'h05, 8'h03, 1'b0, got, acc, lat, r, co, ov);
        tests_run++;
        if (got !== 1'b1 || r !== 8'h08 || co !== 1'b0 || ov !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_reset_add: got done=%b r=%h co=%b ov=%b, want 1 08 0 0",
                     got, r, co, ov);
        end
    endtask

    task automatic test_random();
        logic got, acc, co, ov, cin;
        logic [W-1:0] a, b, r;
        logic [W:0] exp_s;
        int lat;
        for (int i = 0; i < 200; i++) begin
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            exp_s = ref_sum(a, b, cin);
            run_op(a, b, cin, got, acc, lat, r, co, ov);
            tests_run++;
            if (got !== 1'b1 || acc !== 1'b1 || lat != int'(W)) begin
                tests_failed++;
                $display("FAIL rand_timing %0d: got done=%b accept=%b latency=%0d, want 1 1 %0d",
                         i, got, acc, lat, W);
            end
            tests_run++;
            if ({co, r} !== exp_s || ov !== ref_ovf(a, b, cin)) begin
                tests_failed++;
                $display("FAIL rand_sum %0d: a=%h b=%h cin=%b got co/r=%b/%h ov=%b, want %b/%h %b",
                         i, a, b, cin, co, r, ov, exp_s[W], exp_s[W-1:0], ref_ovf(a, b, cin));
            end
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_directed();
        test_start_held();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Bit-serial adder sequencer placed directly upstream of the team's one-bit full-adder cell (ports operandX, operandY, carryIn, sum, carryOut).
- Latches two WIDTH-bit operands and feeds one LSB-first bit pair per clock into the cell.
- Registers the cell's carryOut as the next carryIn and shifts each sum bit into a result register.
- Reports completion with a one-cycle done pulse; supplies the multi-bit add for the CPU datapath without a ripple-carry array.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin an add; sampled only in IDLE.
- operandA  input  WIDTH  first addend; captured on the accepted start edge.
- operandB  input  WIDTH  second addend; captured on the accepted start edge.
- carryIn  input  1  initial carry; captured on the accepted start edge.
- busy  output  1  high while in the SHIFT state.
- done  output  1  high for exactly one cycle (DONE state) when the result is complete.
- result  output  WIDTH  sum bits, registered.
- carryOut  output  1  final carry out of the MSB, registered.
- overflow  output  1  two's-complement overflow flag, registered.

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE; busy=0, done=0, result=0, carryOut=0, overflow=0; internal shift registers, carry flop and counter cleared. The first start is accepted on the first rising edge after rst_n deasserts.
- Internal state: shift regs a_sr, b_sr (WIDTH each), carry flop c, counter cnt.
- State machine:
  - IDLE: busy=0. On an edge with start=1:
    - a_sr<=operandA, b_sr<=operandB, c<=carryIn, cnt<=0.
    - Clear result, carryOut and overflow.
    - Go to SHIFT.
  - SHIFT: busy=1. Each edge:
    - Full-adder cell sees operandX=a_sr[0], operandY=b_sr[0], carryIn=c.
    - result<={sum, result[WIDTH-1:1]}; a_sr and b_sr shift right by 1; c<=cell carryOut; cnt<=cnt+1.
    - On the edge where cnt==WIDTH-1: carryOut<=cell carryOut, overflow<=c ^ cell carryOut (carry into MSB xor carry out of MSB); go to DONE.
  - DONE: busy=0, done=1 for this single cycle. Next edge returns to IDLE unconditionally.
- Latency: start accepted at edge k; SHIFT occupies edges k+1..k+WIDTH; done is high in the cycle following edge k+WIDTH. Minimum start-to-start spacing is WIDTH+2 edges.
- Result hold: result, carryOut and overflow stay stable from DONE until the next accepted start.
- Arithmetic: {carryOut,result} == operandA + operandB + carryIn, computed modulo 2^(WIDTH+1).
- start in SHIFT or DONE is ignored: no restart, no operand recapture, no error flag.
- Operand inputs may change freely after the start edge without effect.
- Reset mid-SHIFT aborts the operation: all outputs zero, no done pulse.
- No combinational path from inputs to outputs.

Test Plan:
- WIDTH=8: A=0x0F, B=0x01, cin=0, start at edge 0 -> busy high for edges 1..8; done high one cycle after edge 8; result=0x10, carryOut=0, overflow=0.
- A=0xFF, B=0x01, cin=0 -> result=0x00, carryOut=1, overflow=0; A=0x7F, B=0x01, cin=0 -> result=0x80, carryOut=0, overflow=1.
- A=0x80, B=0x80, cin=1 -> result=0x01, carryOut=1, overflow=1; done pulses exactly once; outputs held until the next start.
- Start held high continuously with A=0x11, B=0x22, then inputs changed to A=0xAA, B=0x55 during SHIFT -> first result=0x33; the next op starts only from IDLE, WIDTH+2 edges after the first accept.
- rst_n pulsed low during cycle 4 of SHIFT -> outputs 0 immediately (asynchronous); no done pulse; a fresh start with A=0x05, B=0x03 -> result=0x08.
- 200 random A/B/cin back-to-back ops -> each {carryOut,result} == A+B+cin; overflow == (A[7]==B[7]) && (result[7]!=A[7]).
